// File: rtl/aes_pkg.sv
// Shared AES loader definitions: FSM state encoding, word/block geometry and
// the legal key-length / round-count pairings.
package aes_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_DATA,
    COMPUTE,
    SEND
  } aesState_e;

  function automatic bit aesLegalCfg(input int nk, input int nr);
    return (nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14);
  endfunction

  // The word counter indexes key words and also the four block words.
  function automatic int aesCntW(input int nk);
    return (nk > BLOCK_WORDS) ? $clog2(nk) : $clog2(BLOCK_WORDS);
  endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// MSB-first word-insertion register: each accepted word enters at the bottom,
// so after Words shifts the first word sits in the top slot.
module aes_word_shifter
  import aes_pkg::*;
#(
  parameter int Words = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shiftEn,
  input  logic [WORD_W-1:0]       wordIn,
  output logic [Words*WORD_W-1:0] regOut
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regOut <= '0;
    end else if (shiftEn) begin
      regOut <= {regOut[Words*WORD_W-WORD_W-1:0], wordIn};
    end
  end

endmodule

// File: rtl/aes_serial_loader.sv
// Serial key/plaintext loader around a combinational AES core, streaming the
// ciphertext back out as four words. Optional feature macro: AES_KEY_RETAIN_EN.
//
// state     | meaning
// LOAD_KEY  | accepting key words, MSB word first (or a key-skip data word)
// LOAD_DATA | accepting the four plaintext words
// COMPUTE   | one cycle for the core; result registered at its end
// SEND      | presenting ciphertext words under out_valid/out_ready
module aes_serial_loader
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_data,
`ifdef AES_KEY_RETAIN_EN
  input  logic                          in_key_skip,
`endif
  output logic [BLOCK_WORDS*WORD_W-1:0] enc_data,
  output logic [Nk*WORD_W-1:0]          enc_key,
  input  logic [BLOCK_WORDS*WORD_W-1:0] enc_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_last,
  output logic                          busy
);

  if (!aesLegalCfg(Nk, Nr)) begin : gBadCfg
    $error("aes_serial_loader: illegal Nk/Nr pairing");
  end

  localparam int CNT_W = aesCntW(Nk);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(Nk - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_WORDS - 1);

  aesState_e state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic rdyEn, inXfer, outXfer, keyShift, dataShift, skipTake;
  logic [BLOCK_WORDS*WORD_W-1:0] resReg;

  // Keeps in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdyEn <= 1'b0;
    else        rdyEn <= 1'b1;
  end

  assign in_ready  = rdyEn && (state == LOAD_KEY || state == LOAD_DATA);
  assign inXfer    = in_valid && in_ready;
  assign out_valid = (state == SEND);
  assign outXfer   = out_valid && out_ready;
  assign busy      = !(state == LOAD_KEY && cnt == '0);
  assign out_last  = (state == SEND) && (cnt == BLK_LAST);

`ifdef AES_KEY_RETAIN_EN
  logic keyValid;

  // Cleared when a new key starts so a half-written key is never reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        keyValid <= 1'b0;
    else if (keyShift) keyValid <= (cnt == KEY_LAST);
  end

  assign skipTake = in_key_skip && keyValid;
`else
  assign skipTake = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_KEY;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    keyShift  = 1'b0;
    dataShift = 1'b0;
    unique case (state)
      LOAD_KEY: begin
        if (inXfer) begin
          if (skipTake && cnt == '0) begin
            // This word is plaintext word 0; the retained key stays put.
            dataShift = 1'b1;
            stateNxt  = LOAD_DATA;
            cntNxt    = CNT_W'(1);
          end else begin
            keyShift = 1'b1;
            if (cnt == KEY_LAST) begin
              stateNxt = LOAD_DATA;
              cntNxt   = '0;
            end else begin
              cntNxt = cnt + CNT_W'(1);
            end
          end
        end
      end
      LOAD_DATA: begin
        if (inXfer) begin
          dataShift = 1'b1;
          if (cnt == BLK_LAST) begin
            stateNxt = COMPUTE;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
      end
      COMPUTE: begin
        stateNxt = SEND;
        cntNxt   = '0;
      end
      SEND: begin
        if (outXfer) begin
          if (cnt == BLK_LAST) begin
            stateNxt = LOAD_KEY;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        stateNxt = LOAD_KEY;
        cntNxt   = '0;
      end
    endcase
  end

  aes_word_shifter #(.Words(Nk)) uKeyShifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .shiftEn (keyShift),
    .wordIn  (in_data),
    .regOut  (enc_key)
  );

  aes_word_shifter #(.Words(BLOCK_WORDS)) uDataShifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .shiftEn (dataShift),
    .wordIn  (in_data),
    .regOut  (enc_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                resReg <= '0;
    else if (state == COMPUTE) resReg <= enc_result;
  end

  always_comb begin
    out_data = resReg[31:0];
    case (cnt[1:0])
      2'd0:    out_data = resReg[127:96];
      2'd1:    out_data = resReg[95:64];
      2'd2:    out_data = resReg[63:32];
      default: out_data = resReg[31:0];
    endcase
  end

endmodule

// File: tb/tb_aes_serial_loader.sv
// Scoreboard bench for aes_serial_loader: AES-128 and AES-256 instances driven
// with FIPS-197 vectors through a lookup stand-in for the encryption core.
module tb_aes_serial_loader;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BAD   = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         inValid4 = 1'b0, outReady4 = 1'b1, inKeySkip4 = 1'b0;
  logic         inReady4, outValid4, outLast4, busy4;
  logic [31:0]  inData4 = '0, outData4;
  logic [127:0] encData4, encKey4, encResult4;

  logic         inValid8 = 1'b0, outReady8 = 1'b1, inKeySkip8 = 1'b0;
  logic         inReady8, outValid8, outLast8, busy8;
  logic [31:0]  inData8 = '0, outData8;
  logic [127:0] encData8, encResult8;
  logic [255:0] encKey8;

  // Core stand-in: known answers for the FIPS vectors, a poison value otherwise.
  assign encResult4 = (encKey4 == K128 && encData4 == PT) ? CT128 : BAD;
  assign encResult8 = (encKey8 == K256 && encData8 == PT) ? CT256 : BAD;

  aes_serial_loader #(.Nk(4), .Nr(10)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4), .in_data(inData4),
`ifdef AES_KEY_RETAIN_EN
    .in_key_skip(inKeySkip4),
`endif
    .enc_data(encData4), .enc_key(encKey4), .enc_result(encResult4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .out_last(outLast4), .busy(busy4)
  );

  aes_serial_loader #(.Nk(8), .Nr(14)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8), .in_data(inData8),
`ifdef AES_KEY_RETAIN_EN
    .in_key_skip(inKeySkip8),
`endif
    .enc_data(encData8), .enc_key(encKey8), .enc_result(encResult8),
    .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8),
    .out_last(outLast8), .busy(busy8)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } expW_t;

  expW_t q4[$];
  expW_t q8[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitors: compare the queue head whenever a word is presented; pop on transfer.
  always @(negedge clk) begin
    if (rst_n && outValid4) begin
      chk("dut4 in_ready low while sending", inReady4, 0);
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4 unexpected word: got %0h required none", outData4);
      end else begin
        chk("dut4 out_data", outData4, q4[0].d);
        chk("dut4 out_last", outLast4, q4[0].l);
        if (outReady4) void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && outValid8) begin
      chk("dut8 in_ready low while sending", inReady8, 0);
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8 unexpected word: got %0h required none", outData8);
      end else begin
        chk("dut8 out_data", outData8, q8[0].d);
        chk("dut8 out_last", outLast8, q8[0].l);
        if (outReady8) void'(q8.pop_front());
      end
    end
  end

  task automatic pushWord(input int d, input logic [31:0] w, input bit skip, input bit gap);
    int n = 0;
    logic rdy = 1'b0;
    if (d == 0) begin inValid4 = 1'b1; inData4 = w; inKeySkip4 = skip; end
    else        begin inValid8 = 1'b1; inData8 = w; inKeySkip8 = skip; end
    do begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? inReady4 : inReady8;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL dut%0d in_ready timeout: got 0 required 1", d);
    end
    @(posedge clk);
    #1;
    if (d == 0) begin inValid4 = 1'b0; inData4 = 32'hffffffff; inKeySkip4 = 1'b0; end
    else        begin inValid8 = 1'b0; inData8 = 32'hffffffff; inKeySkip8 = 1'b0; end
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic loadBlock(input int d, input bit withKey, input bit skip, input bit gap);
    logic [127:0] ct = (d == 0) ? CT128 : CT256;
    logic [127:0] pt = PT;
    int nk = (d == 0) ? 4 : 8;
    expW_t e;
    for (int i = 0; i < 4; i++) begin
      e.d = ct[127-32*i -: 32];
      e.l = (i == 3);
      if (d == 0) q4.push_back(e);
      else        q8.push_back(e);
    end
    if (withKey)
      for (int i = 0; i < nk; i++)
        pushWord(d, 32'h00010203 + i * 32'h04040404, skip && i == 0, gap);
    for (int i = 0; i < 4; i++)
      pushWord(d, pt[127-32*i -: 32], !withKey && skip && i == 0, gap && i != 3);
    @(negedge clk);
    chk("compute cycle has no out_valid", (d == 0) ? outValid4 : outValid8, 0);
    @(negedge clk);
    chk("out_valid two cycles after last word", (d == 0) ? outValid4 : outValid8, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (((d == 0) ? q4.size() : q8.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("all words delivered", (d == 0) ? q4.size() : q8.size(), 0);
    @(negedge clk);
    chk("in_ready back after last word", (d == 0) ? inReady4 : inReady8, 1);
    chk("idle after block", (d == 0) ? busy4 : busy8, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("reset in_ready", inReady4, 0);
    chk("reset out_valid", outValid4, 0);
    chk("reset out_last", outLast4, 0);
    chk("reset busy", busy4, 0);
    chk("reset enc_key", encKey4, 0);
    chk("reset enc_data", encData4, 0);
    chk("reset out_data", outData4, 0);
    chk("reset dut8 in_ready", inReady8, 0);
    chk("reset dut8 enc_key", encKey8, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready before first edge", inReady4, 0);
    @(posedge clk);
    #1;
    chk("in_ready after first edge", inReady4, 1);

    loadBlock(0, 1'b1, 1'b0, 1'b0); drain(0);
    loadBlock(1, 1'b1, 1'b0, 1'b0); drain(1);

    loadBlock(0, 1'b1, 1'b0, 1'b1); drain(0);
    loadBlock(1, 1'b1, 1'b0, 1'b1); drain(1);

    outReady4 = 1'b0;
    loadBlock(0, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) begin
      repeat (5) @(posedge clk);
      #1 outReady4 = 1'b1;
      @(posedge clk);
      #1 outReady4 = 1'b0;
    end
    outReady4 = 1'b1;
    drain(0);

    pushWord(0, 32'h00010203, 1'b0, 1'b0);
    pushWord(0, 32'h04050607, 1'b0, 1'b0);
    chk("busy mid key load", busy4, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", inReady4, 0);
    chk("mid reset busy", busy4, 0);
    chk("mid reset enc_key cleared", encKey4, 0);
    repeat (2) @(negedge clk);
    chk("in_ready held low in reset", inReady4, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset release", inReady4, 1);
    loadBlock(0, 1'b1, 1'b0, 1'b0); drain(0);

`ifdef AES_KEY_RETAIN_EN
    loadBlock(0, 1'b0, 1'b1, 1'b0); drain(0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    loadBlock(0, 1'b1, 1'b1, 1'b0); drain(0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_serial_loader.md
AES_SERIAL_LOADER -- requirements
Module: aes_serial_loader

Interface
REQ-001 SHALL have parameter Nk, default 4, meaning key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default 10, meaning round count passed through to the encryption core (10, 12 or 14).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port in_ready, output, 1, loader accepts a word.
REQ-007 SHALL have port in_data, input, 32, key or plaintext word.
REQ-008 SHALL have port enc_data, output, 128, assembled plaintext to the combinational encryption core.
REQ-009 SHALL have port enc_key, output, Nk*32, assembled key to the core.
REQ-010 SHALL have port enc_result, input, 128, ciphertext returned by the core.
REQ-011 SHALL have port out_valid, output, 1, ciphertext word valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-013 SHALL have port out_data, output, 32, ciphertext word.
REQ-014 SHALL have port out_last, output, 1, high with the 4th ciphertext word.
REQ-015 SHALL have port busy, output, 1, high in every state except LOAD_KEY with word count 0.

Function
REQ-016 SHALL run FSM LOAD_KEY -> LOAD_DATA -> COMPUTE -> SEND -> LOAD_KEY.
REQ-017 SHALL transfer an input word only on a cycle with in_valid=1 and in_ready=1, and an output word only on a cycle with out_valid=1 and out_ready=1.
REQ-018 SHALL drive in_ready=1 in LOAD_KEY and LOAD_DATA, and 0 in COMPUTE and SEND.
REQ-019 SHALL accept the key words first, most-significant word first, into enc_key[Nk*32-1 -: 32] downward, and leave LOAD_KEY after the Nk-th word is accepted.
REQ-020 SHALL accept exactly 4 plaintext words, most-significant first, into enc_data, and enter COMPUTE after the 4th word is accepted.
REQ-021 SHALL hold enc_data and enc_key stable from the COMPUTE cycle until SEND exits.
REQ-022 SHALL spend exactly one cycle in COMPUTE, register enc_result at the end of that cycle, then enter SEND.
REQ-023 SHALL assert out_valid on the first SEND cycle; latency from the accepted 4th data word to the first out_valid is 2 cycles.
REQ-024 SHALL emit enc_result[127:96] first and [31:0] last, with out_last=1 only on the 4th word.
REQ-025 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL return to LOAD_KEY on the cycle the 4th word transfers; in_ready rises on the following cycle.
REQ-027 SHALL keep a word counter wide enough to index the key words (0..Nk-1), wrapping to 0 at each state change.
REQ-028 SHALL ignore in_data when in_ready=0 and ignore out_ready when out_valid=0.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-transaction, immediately enter LOAD_KEY with counter 0 and drive in_ready=0 while reset is asserted.
REQ-030 SHALL reset out_valid, out_last, busy, out_data, enc_data, enc_key and the result register to 0.
REQ-031 SHALL discard any partially loaded key, partially loaded block or unsent ciphertext on reset.
REQ-032 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.

Configuration
REQ-033 SHALL, with AES_KEY_RETAIN_EN defined, add input in_key_skip (1 bit), sampled with the first accepted word in LOAD_KEY with counter 0.
REQ-034 SHALL, when in_key_skip=1 is sampled and a full key has been loaded since reset, treat that word as plaintext word 0 and go to LOAD_DATA with the retained key.
REQ-035 SHALL, when in_key_skip=1 is sampled and no key has been loaded since reset, ignore in_key_skip and treat the word as key word 0.
REQ-036 SHALL, without AES_KEY_RETAIN_EN, omit in_key_skip and require a full key for every block.

Structure
REQ-037 SHALL take from the shared package aes_pkg: the state enum, WORD_W=32, BLOCK_WORDS=4, and the legal Nk/Nr pairs.
REQ-038 SHALL place the MSB-first word-insertion register, used for both key and data, in the one sub-module aes_word_shifter.

Verification
REQ-039 SHALL test the FIPS-197 AES-128 vector: key 00010203..0c0d0e0f, plaintext 00112233..ccddeeff -> out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with out_last on the 4th.
REQ-040 SHALL test AES-256 (Nk=8, Nr=14): key 00..1f, same plaintext -> 8ea2b7ca, 516745bf, eafc4990, 4b496089.
REQ-041 SHALL test backpressure: out_ready=0 for 5 cycles on each word -> words unchanged and none dropped, in_ready=0 until the last transfer.
REQ-042 SHALL test reset after 2 key words -> in_ready=0 during reset, then a full fresh load gives the correct ciphertext.
REQ-043 SHALL test, with AES_KEY_RETAIN_EN, a second block with in_key_skip=1 and 4 words -> ciphertext under the retained key; in_key_skip=1 straight after reset -> first word taken as key.
REQ-044 SHALL test idle gaps: in_valid toggled 1010.. during load -> same ciphertext as the back-to-back case.
